// File: rtl/axi_read_arbiter.sv
// Two-master AXI read-channel arbiter: one grant at a time, held from AR through the final R beat.
// Define ARB_FIXED_PRIO_EN for fixed priority (M1 wins ties); otherwise round-robin.
module axi_read_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int SIZE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     ARID_M0,
    input  logic [ADDR_W-1:0]   ARADDR_M0,
    input  logic [LEN_W-1:0]    ARLEN_M0,
    input  logic [SIZE_W-1:0]   ARSIZE_M0,
    input  logic [1:0]          ARBURST_M0,
    input  logic                ARVALID_M0,
    output logic                ARREADY_M0,
    output logic [ID_W-1:0]     RID_M0,
    output logic [DATA_W-1:0]   RDATA_M0,
    output logic [1:0]          RRESP_M0,
    output logic                RLAST_M0,
    output logic                RVALID_M0,
    input  logic                RREADY_M0,
    input  logic [ID_W-1:0]     ARID_M1,
    input  logic [ADDR_W-1:0]   ARADDR_M1,
    input  logic [LEN_W-1:0]    ARLEN_M1,
    input  logic [SIZE_W-1:0]   ARSIZE_M1,
    input  logic [1:0]          ARBURST_M1,
    input  logic                ARVALID_M1,
    output logic                ARREADY_M1,
    output logic [ID_W-1:0]     RID_M1,
    output logic [DATA_W-1:0]   RDATA_M1,
    output logic [1:0]          RRESP_M1,
    output logic                RLAST_M1,
    output logic                RVALID_M1,
    input  logic                RREADY_M1,
    output logic [ID_W+3:0]     ARID_S,
    output logic [ADDR_W-1:0]   ARADDR_S,
    output logic [LEN_W-1:0]    ARLEN_S,
    output logic [SIZE_W-1:0]   ARSIZE_S,
    output logic [1:0]          ARBURST_S,
    output logic                ARVALID_S,
    input  logic                ARREADY_S,
    input  logic [ID_W+3:0]     RID_S,
    input  logic [DATA_W-1:0]   RDATA_S,
    input  logic [1:0]          RRESP_S,
    input  logic                RLAST_S,
    input  logic                RVALID_S,
    output logic                RREADY_S,
    output logic                len_err
);

    localparam int SID_W = ID_W + 4;
    localparam int CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              state_r;
    logic                grant_r;
`ifdef ARB_FIXED_PRIO_EN
`else
    logic                last_r;
`endif
    logic [LEN_W-1:0]    len_r;
    logic [CNT_W-1:0]    beat_cnt_r;
    logic                arvalid_r;
    logic                len_err_r;
    logic [SID_W-1:0]    arid_r;
    logic [ADDR_W-1:0]   araddr_r;
    logic [LEN_W-1:0]    arlen_r;
    logic [SIZE_W-1:0]   arsize_r;
    logic [1:0]          arburst_r;

    logic                grant_s;
    logic                r_hs_s;
    logic                len_bad_s;
    logic                unused_rid_s;

    // Routing uses the held grant only; the slave-side ID prefix is informational.
    assign unused_rid_s = ^RID_S[SID_W-1:ID_W];

    // Winner selection among the masters requesting in IDLE.
    always_comb begin
        grant_s = 1'b0;
        if (ARVALID_M0 && ARVALID_M1) begin
`ifdef ARB_FIXED_PRIO_EN
            grant_s = 1'b1;
`else
            grant_s = ~last_r;
`endif
        end else if (ARVALID_M1) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // R handshake on the shared path and the burst-length verdict for that beat.
    always_comb begin
        r_hs_s    = 1'b0;
        len_bad_s = 1'b0;
        if (state_r == ST_DATA) begin
            r_hs_s = RVALID_S && (grant_r ? RREADY_M1 : RREADY_M0);
        end else begin
            r_hs_s = 1'b0;
        end
        if (RLAST_S) begin
            len_bad_s = (beat_cnt_r != {1'b0, len_r});
        end else begin
            len_bad_s = (beat_cnt_r == {1'b0, len_r});
        end
    end

    // Arbitration FSM with registered AR fields and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= 1'b0;
`ifdef ARB_FIXED_PRIO_EN
`else
            last_r     <= 1'b1;
`endif
            len_r      <= {LEN_W{1'b0}};
            beat_cnt_r <= {CNT_W{1'b0}};
            arvalid_r  <= 1'b0;
            len_err_r  <= 1'b0;
            arid_r     <= {SID_W{1'b0}};
            araddr_r   <= {ADDR_W{1'b0}};
            arlen_r    <= {LEN_W{1'b0}};
            arsize_r   <= {SIZE_W{1'b0}};
            arburst_r  <= 2'b00;
        end else begin
            len_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ARVALID_M0 || ARVALID_M1) begin
                        grant_r   <= grant_s;
`ifdef ARB_FIXED_PRIO_EN
`else
                        last_r    <= grant_s;
`endif
                        arvalid_r <= 1'b1;
                        arid_r    <= {3'b000, grant_s, (grant_s ? ARID_M1 : ARID_M0)};
                        araddr_r  <= grant_s ? ARADDR_M1  : ARADDR_M0;
                        arlen_r   <= grant_s ? ARLEN_M1   : ARLEN_M0;
                        arsize_r  <= grant_s ? ARSIZE_M1  : ARSIZE_M0;
                        arburst_r <= grant_s ? ARBURST_M1 : ARBURST_M0;
                        state_r   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (ARREADY_S) begin
                        arvalid_r  <= 1'b0;
                        len_r      <= arlen_r;
                        beat_cnt_r <= {CNT_W{1'b0}};
                        state_r    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs_s) begin
                        len_err_r <= len_bad_s;
                        if (beat_cnt_r != {CNT_W{1'b1}}) begin
                            beat_cnt_r <= beat_cnt_r + {{LEN_W{1'b0}}, 1'b1};
                        end
                        if (RLAST_S) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    arvalid_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign ARVALID_S = arvalid_r;
    assign ARID_S    = arid_r;
    assign ARADDR_S  = araddr_r;
    assign ARLEN_S   = arlen_r;
    assign ARSIZE_S  = arsize_r;
    assign ARBURST_S = arburst_r;
    assign len_err   = len_err_r;

    // AR acceptance is reflected straight to the granted master.
    always_comb begin
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        if (state_r == ST_ADDR) begin
            if (grant_r) begin
                ARREADY_M1 = ARREADY_S;
            end else begin
                ARREADY_M0 = ARREADY_S;
            end
        end else begin
            ARREADY_M0 = 1'b0;
            ARREADY_M1 = 1'b0;
        end
    end

    // R beats pass through with zero latency to the granted master only.
    always_comb begin
        RID_M0    = {ID_W{1'b0}};
        RDATA_M0  = {DATA_W{1'b0}};
        RRESP_M0  = 2'b00;
        RLAST_M0  = 1'b0;
        RVALID_M0 = 1'b0;
        RID_M1    = {ID_W{1'b0}};
        RDATA_M1  = {DATA_W{1'b0}};
        RRESP_M1  = 2'b00;
        RLAST_M1  = 1'b0;
        RVALID_M1 = 1'b0;
        RREADY_S  = 1'b0;
        if (state_r == ST_DATA) begin
            if (grant_r) begin
                RID_M1    = RID_S[ID_W-1:0];
                RDATA_M1  = RDATA_S;
                RRESP_M1  = RRESP_S;
                RLAST_M1  = RLAST_S;
                RVALID_M1 = RVALID_S;
                RREADY_S  = RREADY_M1;
            end else begin
                RID_M0    = RID_S[ID_W-1:0];
                RDATA_M0  = RDATA_S;
                RRESP_M0  = RRESP_S;
                RLAST_M0  = RLAST_S;
                RVALID_M0 = RVALID_S;
                RREADY_S  = RREADY_M0;
            end
        end else begin
            RREADY_S = 1'b0;
        end
    end

endmodule
